residual_select_sched: RTL and testbench



---
 rtl/residual_pkg.sv | 35 +++
 rtl/residual_select_sched_timeout.sv | 28 ++
 rtl/residual_select_sched.sv | 199 +++++++++++++++++++
 tb/tb_residual_select_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/residual_pkg.sv
// Shared definitions for the intra residual block scheduler: mode codes,
// state encoding and default sizes.
package residual_pkg;

    localparam int BLK_CNT_W_DEF   = 8;
    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic [1:0] MODE_P0   = 2'b00;
    localparam logic [1:0] MODE_P1   = 2'b01;
    localparam logic [1:0] MODE_P2   = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_PRED = 3'd2;
    localparam logic [2:0] ST_GO        = 3'd3;
    localparam logic [2:0] ST_WAIT_SEL  = 3'd4;
    localparam logic [2:0] ST_OUTPUT    = 3'd5;
    localparam logic [2:0] ST_NEXT      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_PRED = ST_WAIT_PRED,
        S_GO        = ST_GO,
        S_WAIT_SEL  = ST_WAIT_SEL,
        S_OUTPUT    = ST_OUTPUT,
        S_NEXT      = ST_NEXT
    } sched_state_t;

    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/residual_select_sched_timeout.sv
// Wait-state watchdog: down-counter loaded on entry to a wait, expires at terminal count zero.
module sched_timeout_cnt #(
    parameter int MAX_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(MAX_CYC);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/residual_select_sched.sv
// Raster-order 4x4 block scheduler driving the three predictors and the residual selector.
// Optional per-mode accepted-block histogram enabled by RESIDUAL_SCHED_MODE_HIST_EN.
//
// state     | meaning
// IDLE      | waiting for frame_start, config latched on acceptance
// ISSUE     | one-cycle start pulse to all predictors
// WAIT_PRED | waiting for all predictors done (watchdog armed)
// GO        | selector released for one cycle (stall low)
// WAIT_SEL  | waiting for selector result (watchdog armed)
// OUTPUT    | result held valid until downstream accepts
// NEXT      | advance block position or finish the frame
module residual_select_sched
    import residual_pkg::*;
#(
    parameter int BLK_CNT_W   = BLK_CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int NUM_PRED    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [1:0]           cfg_mode,
    input  logic [BLK_CNT_W-1:0] cfg_blocks_w,
    input  logic [BLK_CNT_W-1:0] cfg_blocks_h,
    output logic [2:0]           pred_start,
    input  logic [2:0]           pred_done,
    output logic [1:0]           sel_mode_select,
    output logic                 sel_stall,
    input  logic                 sel_busy,
    input  logic                 sel_ready,
    input  logic [1:0]           sel_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_mode,
    output logic [BLK_CNT_W-1:0] out_blk_x,
    output logic [BLK_CNT_W-1:0] out_blk_y,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err_timeout
`ifdef RESIDUAL_SCHED_MODE_HIST_EN
    ,
    output logic [15:0]          hist_m0,
    output logic [15:0]          hist_m1,
    output logic [15:0]          hist_m2
`endif
);

    if (NUM_PRED != 3) begin : g_num_pred_check
        $error("residual_select_sched supports exactly three predictors");
    end

    sched_state_t         state;
    logic [1:0]           cfg_mode_q;
    logic [BLK_CNT_W-1:0] cfg_w_q;
    logic [BLK_CNT_W-1:0] cfg_h_q;
    logic                 seen_busy;
    logic                 tmo_load;
    logic                 tmo_en;
    logic                 tmo_expired;
    logic                 auto_mode;
    logic                 preds_done;
    logic                 sel_done;
    logic                 last_blk;

    assign auto_mode       = is_auto(cfg_mode_q);
    assign preds_done      = &pred_done;
    // The selector parks sel_ready high in auto mode, so only a busy pulse marks completion.
    assign sel_done        = auto_mode ? (seen_busy && !sel_busy) : sel_ready;
    assign last_blk        = (out_blk_x == cfg_w_q) && (out_blk_y == cfg_h_q);
    assign sel_mode_select = cfg_mode_q;
    assign tmo_load        = (state == S_ISSUE) || (state == S_GO);
    assign tmo_en          = (state == S_WAIT_PRED) || (state == S_WAIT_SEL);

    sched_timeout_cnt #(
        .MAX_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cfg_mode_q  <= MODE_P0;
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            seen_busy   <= 1'b0;
            pred_start  <= '0;
            sel_stall   <= 1'b1;
            out_valid   <= 1'b0;
            out_mode    <= '0;
            out_blk_x   <= '0;
            out_blk_y   <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        cfg_mode_q  <= cfg_mode;
                        cfg_w_q     <= cfg_blocks_w;
                        cfg_h_q     <= cfg_blocks_h;
                        out_blk_x   <= '0;
                        out_blk_y   <= '0;
                        err_timeout <= 1'b0;
                        pred_start  <= 3'b111;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pred_start <= '0;
                    state      <= S_WAIT_PRED;
                end
                S_WAIT_PRED: begin
                    if (preds_done) begin
                        sel_stall <= 1'b0;
                        state     <= S_GO;
                    end else if (tmo_expired) begin
                        err_timeout <= 1'b1;
                        out_valid   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_GO: begin
                    sel_stall <= 1'b1;
                    seen_busy <= 1'b0;
                    state     <= S_WAIT_SEL;
                end
                S_WAIT_SEL: begin
                    if (sel_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (sel_done) begin
                        out_mode  <= auto_mode ? sel_mode : cfg_mode_q;
                        out_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else if (tmo_expired) begin
                        err_timeout <= 1'b1;
                        out_valid   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_blk) begin
                        out_blk_x  <= '0;
                        out_blk_y  <= '0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        if (out_blk_x < cfg_w_q) begin
                            out_blk_x <= out_blk_x + BLK_CNT_W'(1);
                        end else begin
                            out_blk_x <= '0;
                            out_blk_y <= out_blk_y + BLK_CNT_W'(1);
                        end
                        pred_start <= 3'b111;
                        state      <= S_ISSUE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RESIDUAL_SCHED_MODE_HIST_EN
    always_ff @(posedge clk) begin
        if (rst || ((state == S_IDLE) && frame_start)) begin
            hist_m0 <= '0;
            hist_m1 <= '0;
            hist_m2 <= '0;
        end else if ((state == S_OUTPUT) && out_ready) begin
            case (out_mode)
                MODE_P0: if (hist_m0 != 16'hFFFF) hist_m0 <= hist_m0 + 16'd1;
                MODE_P1: if (hist_m1 != 16'hFFFF) hist_m1 <= hist_m1 + 16'd1;
                MODE_P2: if (hist_m2 != 16'hFFFF) hist_m2 <= hist_m2 + 16'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_residual_select_sched.sv
// Self-checking bench for residual_select_sched: predictor/selector environment models,
// a transaction monitor, and a frame-level reference of the expected raster block sequence.
module tb_residual_select_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_blocks_w;
    logic [7:0] cfg_blocks_h;
    logic [2:0] pred_start;
    logic [2:0] pred_done = 3'b111;
    logic [1:0] sel_mode_select;
    logic       sel_stall;
    logic       sel_busy = 1'b0;
    logic       sel_ready = 1'b1;
    logic [1:0] sel_mode;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_mode;
    logic [7:0] out_blk_x;
    logic [7:0] out_blk_y;
    logic       frame_done;
    logic       busy;
    logic       err_timeout;
`ifdef RESIDUAL_SCHED_MODE_HIST_EN
    logic [15:0] hist_m0, hist_m1, hist_m2;
`endif

    residual_select_sched dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .cfg_mode        (cfg_mode),
        .cfg_blocks_w    (cfg_blocks_w),
        .cfg_blocks_h    (cfg_blocks_h),
        .pred_start      (pred_start),
        .pred_done       (pred_done),
        .sel_mode_select (sel_mode_select),
        .sel_stall       (sel_stall),
        .sel_busy        (sel_busy),
        .sel_ready       (sel_ready),
        .sel_mode        (sel_mode),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_mode        (out_mode),
        .out_blk_x       (out_blk_x),
        .out_blk_y       (out_blk_y),
        .frame_done      (frame_done),
        .busy            (busy),
        .err_timeout     (err_timeout)
`ifdef RESIDUAL_SCHED_MODE_HIST_EN
        ,
        .hist_m0         (hist_m0),
        .hist_m1         (hist_m1),
        .hist_m2         (hist_m2)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Predictors: drop done on start, raise it pdly cycles later; stuck ones never finish.
    int       pdly[3] = '{0, 0, 0};
    int       pcnt[3] = '{0, 0, 0};
    logic [2:0] pstuck = 3'b000;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pred_start[i]) begin
                pred_done[i] <= (pdly[i] == 0) && !pstuck[i];
                pcnt[i]      <= pdly[i];
            end else if (!pred_done[i] && !pstuck[i]) begin
                if (pcnt[i] <= 1) pred_done[i] <= 1'b1;
                else              pcnt[i] <= pcnt[i] - 1;
            end
        end
    end

    // Selector: busy for slen cycles after release, then ready; slen==0 leaves it untouched.
    int slen = 1;
    int scnt = 0;
    always @(posedge clk) begin
        if (!sel_stall && slen > 0) begin
            sel_busy  <= 1'b1;
            sel_ready <= 1'b0;
            scnt      <= slen - 1;
        end else if (sel_busy) begin
            if (scnt == 0) begin
                sel_busy  <= 1'b0;
                sel_ready <= 1'b1;
            end else begin
                scnt <= scnt - 1;
            end
        end
    end

    int          cyc = 0, ps_cnt = 0, ps_cyc = 0, stall_cnt = 0, fd_cnt = 0, err_cyc = 0, stab_err = 0;
    bit          hold_v = 0, err_prev = 0;
    logic [17:0] hold_val;
    logic [17:0] got_q[$];
    int          acc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (pred_start == 3'b111) begin ps_cnt++; ps_cyc = cyc; end
        if (!sel_stall) stall_cnt++;
        if (frame_done) fd_cnt++;
        if (err_timeout && !err_prev) err_cyc = cyc;
        err_prev = err_timeout;
        if (out_valid) begin
            if (hold_v && ({out_mode, out_blk_x, out_blk_y} !== hold_val)) stab_err++;
            if (out_ready) begin
                got_q.push_back({out_mode, out_blk_x, out_blk_y});
                acc_q.push_back(cyc);
                hold_v = 0;
            end else begin
                hold_v   = 1;
                hold_val = {out_mode, out_blk_x, out_blk_y};
            end
        end else begin
            hold_v = 0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [7:0] w, input logic [7:0] h);
        got_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        cfg_mode = m; cfg_blocks_w = w; cfg_blocks_h = h; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start  = 1'b0;
        cfg_mode     = 2'($urandom);
        cfg_blocks_w = 8'($urandom);
        cfg_blocks_h = 8'($urandom);
    endtask

    task automatic run_frame(input bit rand_ready);
        int fd0;
        int n;
        fd0 = fd_cnt;
        n   = 0;
        while (fd_cnt == fd0 && n < 5000) begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        out_ready = 1'b1;
        chk("frame_done_pulse", fd_cnt - fd0, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        settle();
        while (!out_valid && n < 300) begin settle(); n++; end
        chk(tag, out_valid, 1);
    endtask

    task automatic check_frame(input logic [1:0] m, input logic [7:0] w, input logic [7:0] h,
                               input logic [1:0] smode, input int st0, input int ps0);
        int         nb;
        int         k;
        logic [1:0] em;
        nb = (int'(w) + 1) * (int'(h) + 1);
        em = (m == 2'd3) ? smode : m;
        k  = 0;
        chk("blk_count", got_q.size(), nb);
        for (int y = 0; y <= int'(h); y++) begin
            for (int x = 0; x <= int'(w); x++) begin
                if (k < got_q.size()) chk("blk_mode_x_y", got_q[k], {14'd0, em, 8'(x), 8'(y)});
                k++;
            end
        end
        chk("stall_low_cycles", stall_cnt - st0, nb);
        chk("pred_start_pulses", ps_cnt - ps0, nb);
        chk("valid_hold_stable", stab_err, 0);
        chk("busy_after_frame", busy, 0);
`ifdef RESIDUAL_SCHED_MODE_HIST_EN
        chk("hist_m0", hist_m0, (em == 2'd0) ? nb : 0);
        chk("hist_m1", hist_m1, (em == 2'd1) ? nb : 0);
        chk("hist_m2", hist_m2, (em == 2'd2) ? nb : 0);
`endif
    endtask

    task automatic full_frame(input logic [1:0] m, input logic [7:0] w, input logic [7:0] h,
                              input logic [1:0] smode, input bit rr);
        int st0;
        int ps0;
        sel_mode = smode;
        st0 = stall_cnt;
        ps0 = ps_cnt;
        start_frame(m, w, h);
        run_frame(rr);
        check_frame(m, w, h, smode, st0, ps0);
    endtask

    initial begin
        int fd0;
        int n;
        rst = 1'b1; frame_start = 1'b0; cfg_mode = 2'b10; cfg_blocks_w = 8'd0; cfg_blocks_h = 8'd0;
        sel_mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pred_start", pred_start, 0);
        chk("rst_sel_stall", sel_stall, 1);
        chk("rst_sel_mode_select", sel_mode_select, 0);
        chk("rst_out_mode_xy", {out_mode, out_blk_x, out_blk_y}, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;

        // Manual mode 01, two blocks, predictors two cycles late.
        pdly = '{2, 2, 2}; slen = 1;
        full_frame(2'b01, 8'd1, 8'd0, 2'b11, 0);

        // Auto mode, selector busy three cycles, picks predictor 2.
        pdly = '{1, 0, 2}; slen = 3;
        full_frame(2'b11, 8'd2, 8'd1, 2'b10, 0);

        // Manual latency: everything done immediately gives one block every 6 cycles.
        pdly = '{0, 0, 0}; slen = 0;
        full_frame(2'b00, 8'd3, 8'd0, 2'b01, 0);
        for (int i = 1; i < acc_q.size(); i++) chk("manual_block_period", acc_q[i] - acc_q[i-1], 6);

        // Backpressure: result held while out_ready low; one ready cycle takes one block.
        pdly = '{1, 1, 1}; slen = 1; sel_mode = 2'b00; out_ready = 1'b0;
        start_frame(2'b10, 8'd1, 8'd0);
        wait_valid("bp_valid_first");
        repeat (10) settle();
        chk("bp_still_valid", out_valid, 1);
        chk("bp_held_value", {out_mode, out_blk_x, out_blk_y}, {2'b10, 8'd0, 8'd0});
        chk("bp_none_accepted", got_q.size(), 0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        wait_valid("bp_valid_second");
        chk("bp_one_accepted", got_q.size(), 1);
        chk("bp_next_pos", {out_blk_x, out_blk_y}, {8'd1, 8'd0});
        run_frame(0);
        check_frame(2'b10, 8'd1, 8'd0, 2'b00, stall_cnt - 2, ps_cnt - 2);

        // Predictor 2 never finishes: watchdog abort after 256 cycles in WAIT_PRED.
        pdly = '{0, 0, 0}; pstuck = 3'b100; slen = 1;
        fd0 = fd_cnt;
        start_frame(2'b00, 8'd0, 8'd0);
        n = 0;
        while (!err_timeout && n < 400) begin settle(); n++; end
        chk("tmo_err_set", err_timeout, 1);
        chk("tmo_cycles_from_issue", err_cyc - ps_cyc, 257);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_valid", out_valid, 0);
        repeat (3) settle();
        chk("tmo_no_frame_done", fd_cnt - fd0, 0);
        chk("tmo_no_block", got_q.size(), 0);
        chk("tmo_sticky", err_timeout, 1);
        pstuck = 3'b000;
        repeat (4) settle();
        start_frame(2'b01, 8'd0, 8'd0);
        chk("tmo_cleared_by_start", err_timeout, 0);
        run_frame(0);
        chk("tmo_recover_block", got_q.size(), 1);

        // Reset while waiting on the selector.
        slen = 6; pdly = '{1, 1, 1};
        fd0 = fd_cnt;
        start_frame(2'b10, 8'd1, 8'd1);
        n = 0;
        settle();
        while (sel_stall && n < 300) begin settle(); n++; end
        chk("rst_mid_go_seen", sel_stall, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        settle();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_sel_stall", sel_stall, 1);
        chk("rstmid_sel_mode_select", sel_mode_select, 0);
        chk("rstmid_pred_start", pred_start, 0);
        chk("rstmid_out_mode_xy", {out_mode, out_blk_x, out_blk_y}, 0);
        chk("rstmid_no_frame_done", fd_cnt - fd0, 0);
        repeat (8) settle();
        slen = 1;
        full_frame(2'b01, 8'd0, 8'd0, 2'b00, 0);

        // 1x1 frame with a second frame_start issued while busy.
        fd0 = fd_cnt;
        got_q.delete();
        start_frame(2'b00, 8'd0, 8'd0);
        @(posedge clk); #1; cfg_blocks_w = 8'd3; frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        run_frame(0);
        repeat (20) settle();
        chk("dup_start_blocks", got_q.size(), 1);
        chk("dup_start_frame_dones", fd_cnt - fd0, 1);
        chk("dup_start_idle", busy, 0);

        // Randomised frames against the raster-order reference.
        for (int f = 0; f < 8; f++) begin
            logic [1:0] m;
            logic [1:0] sm;
            logic [7:0] w;
            logic [7:0] h;
            m  = 2'($urandom_range(0, 3));
            sm = 2'($urandom_range(0, 2));
            w  = 8'($urandom_range(0, 3));
            h  = 8'($urandom_range(0, 2));
            for (int i = 0; i < 3; i++) pdly[i] = $urandom_range(0, 3);
            slen = $urandom_range(1, 4);
            full_frame(m, w, h, sm, f[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
